grid_painter: RTL

- Parametrised successor to the single-colour screen clear: a raster pixel generator feeding the vga_adapter plot interface (x, y, colour, plot).
- Three modes, one pixel per clock:
  - clear the whole screen;
  - draw an N x N BattleChip board (grid lines over a background);
  - fill the interior of one cell (hit/miss/ship marking).
- Sits between the game controller and the VGA adapter; start/done handshake is level-based, as in the existing screen-clear block.

---
 rtl/grid_painter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/grid_painter.sv
// rtl/grid_painter.sv - raster pixel generator for screen clear, board grid and cell fill
// One pixel per clock into the VGA adapter plot port; start/done is a level handshake.
module grid_painter #(
  parameter int SCR_W  = 320,
  parameter int SCR_H  = 240,
  parameter int X_W    = 9,
  parameter int Y_W    = 8,
  parameter int GRID_N = 10,
  parameter int CELL   = 20,
  parameter int X0     = 60,
  parameter int Y0     = 20,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [2:0]       colour,
  input  logic [2:0]       line_colour,
  input  logic [IDX_W-1:0] row,
  input  logic [IDX_W-1:0] col,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [X_W-1:0]   vga_x,
  output logic [Y_W-1:0]   vga_y,
  output logic [2:0]       vga_colour,
  output logic             vga_plot
);

  localparam int PH_W = (CELL > 2) ? $clog2(CELL) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CELL - 1);
  localparam logic [1:0] M_BRD  = 2'b01;
  localparam logic [1:0] M_CELL = 2'b10;
  localparam logic [1:0] M_RSV  = 2'b11;
  localparam logic [X_W-1:0] X0_C = X_W'(X0);
  localparam logic [X_W-1:0] CELL_X = X_W'(CELL);
  localparam logic [X_W-1:0] BOARD_X = X_W'(GRID_N * CELL);
  localparam logic [X_W-1:0] SCRX_MAX = X_W'(SCR_W - 1);
  localparam logic [X_W-1:0] X_ONE = X_W'(1);
  localparam logic [Y_W-1:0] Y0_C = Y_W'(Y0);
  localparam logic [Y_W-1:0] CELL_Y = Y_W'(CELL);
  localparam logic [Y_W-1:0] BOARD_Y = Y_W'(GRID_N * CELL);
  localparam logic [Y_W-1:0] SCRY_MAX = Y_W'(SCR_H - 1);
  localparam logic [Y_W-1:0] Y_ONE = Y_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q;
  logic [1:0]      mode_q;
  logic [2:0]      fill_q, line_q, vga_colour_q;
  logic [X_W-1:0]  xmax_q, xmin_q, vga_x_q;
  logic [Y_W-1:0]  ymax_q, vga_y_q;
  logic [PH_W-1:0] px_q, py_q;
  logic            busy_q, done_q, err_q, vga_plot_q;

  logic [X_W-1:0]  win_xmin, win_xmax, cell_x, x_d;
  logic [Y_W-1:0]  win_ymin, win_ymax, cell_y, y_d;
  logic [PH_W-1:0] px_d, py_d, px_step, py_step;
  logic [2:0]      colour_d;
  logic            req_bad, x_end, last;

  // Window bounds for the request currently on the inputs, used only at latch time.
  always_comb begin
    cell_x   = X0_C + X_W'(col) * CELL_X;
    cell_y   = Y0_C + Y_W'(row) * CELL_Y;
    win_xmin = '0;
    win_xmax = SCRX_MAX;
    win_ymin = '0;
    win_ymax = SCRY_MAX;
    case (mode)
      M_BRD: begin
        win_xmin = X0_C;
        win_xmax = X0_C + BOARD_X;
        win_ymin = Y0_C;
        win_ymax = Y0_C + BOARD_Y;
      end
      M_CELL: begin
        win_xmin = cell_x + X_ONE;
        win_xmax = cell_x + CELL_X - X_ONE;
        win_ymin = cell_y + Y_ONE;
        win_ymax = cell_y + CELL_Y - Y_ONE;
      end
      default: ;
    endcase
    req_bad = (mode == M_RSV) ||
              ((mode == M_CELL) && ((32'(row) >= GRID_N) || (32'(col) >= GRID_N)));
  end

  // Next raster position; phase counters track the offset modulo CELL without a divider.
  always_comb begin
    x_end   = (vga_x_q == xmax_q);
    last    = x_end && (vga_y_q == ymax_q);
    px_step = (px_q == PH_LAST) ? '0 : px_q + 1'b1;
    py_step = (py_q == PH_LAST) ? '0 : py_q + 1'b1;
    if (x_end) begin
      x_d  = xmin_q;
      px_d = '0;
      y_d  = vga_y_q + 1'b1;
      py_d = py_step;
    end else begin
      x_d  = vga_x_q + 1'b1;
      px_d = px_step;
      y_d  = vga_y_q;
      py_d = py_q;
    end
    colour_d = ((mode_q == M_BRD) && ((px_d == '0) || (py_d == '0))) ? line_q : fill_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mode_q       <= '0;
      fill_q       <= '0;
      line_q       <= '0;
      xmin_q       <= '0;
      xmax_q       <= '0;
      ymax_q       <= '0;
      px_q         <= '0;
      py_q         <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          mode_q <= mode;
          fill_q <= colour;
          line_q <= line_colour;
          xmin_q <= win_xmin;
          xmax_q <= win_xmax;
          ymax_q <= win_ymax;
          if (req_bad) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            state_q      <= RUN;
            busy_q       <= 1'b1;
            vga_plot_q   <= 1'b1;
            vga_x_q      <= win_xmin;
            vga_y_q      <= win_ymin;
            px_q         <= '0;
            py_q         <= '0;
            vga_colour_q <= (mode == M_BRD) ? line_colour : colour;
          end
        end
        RUN: if (last) begin
          state_q    <= DONE;
          busy_q     <= 1'b0;
          vga_plot_q <= 1'b0;
          done_q     <= 1'b1;
        end else begin
          vga_x_q      <= x_d;
          vga_y_q      <= y_d;
          px_q         <= px_d;
          py_q         <= py_d;
          vga_colour_q <= colour_d;
        end
        DONE: if (!start) begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;

endmodule
